// File: rtl/char_pkg.sv
// char_pkg: shared definitions for the one-wire character link.
// Holds the receiver state encoding, the default character width and the
// line-level constants common to the transmitter and the receiver.
package char_pkg;

  // Default number of data bits per character.
  localparam int unsigned CHAR_BITS = 8;

  // Line levels: the link idles high and a frame begins with a low start bit.
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;

  // Receiver frame states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/char_r.sv
// char_r: serial character receiver for the one-wire character link.
// Frame: start bit (0), DATA_BITS data bits MSB first, stop bit (1).
// i_rx shares i_clk with the transmitter, so it is sampled directly.
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst       asynchronous reset, active low
//   i_rx        serial line, idle high
//   o_char      last correctly framed character
//   o_valid     one-cycle pulse, o_char updated this cycle
//   o_frame_err one-cycle pulse, stop bit sampled low
//   o_busy      high while a frame is in progress
module char_r
  import char_pkg::*;
#(
  parameter int unsigned DATA_BITS    = CHAR_BITS,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_char,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned CW = $clog2(DATA_BITS) + 1;

  localparam logic [TW-1:0] MID    = TW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [TW-1:0] LAST_T = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST_B = CW'(DATA_BITS - 1);
  // Timer value one cycle after count 0 of the start bit.
  localparam logic [TW-1:0] AFTER0 = (CLKS_PER_BIT == 1) ? '0 : TW'(1);

  rx_state_e state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic [DATA_BITS-1:0] char_q, char_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  logic                 tick;
  logic [TW-1:0]        timer_inc;

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
      char_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // The timer runs from the start edge through the stop sample and wraps
  // explicitly, so every state samples the line at the same count MID.
  always_comb begin
    tick      = (timer_q == MID);
    timer_inc = (timer_q == LAST_T) ? '0 : timer_q + TW'(1);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    char_d  = char_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        cnt_d   = '0;
        if (i_rx == START_LVL) begin
          // This edge is count 0 of the start bit; with MID == 0 it is
          // also the start-bit sample.
          timer_d = AFTER0;
          state_d = (MID == '0) ? DATA : START;
        end
      end
      START: begin
        timer_d = timer_inc;
        if (tick) begin
          if (i_rx == START_LVL) begin
            state_d = DATA;
          end else begin
            timer_d = '0;
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        timer_d = timer_inc;
        if (tick) begin
          sr_d = {sr_q[DATA_BITS-2:0], i_rx};
          if (cnt_q == LAST_B) begin
            cnt_d   = '0;
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      STOP: begin
        timer_d = timer_inc;
        if (tick) begin
          timer_d = '0;
          if (i_rx == LINE_IDLE) begin
            char_d  = sr_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // A held-low line must return high before another start is accepted.
        timer_d = '0;
        if (i_rx == LINE_IDLE) begin
          state_d = IDLE;
        end
      end
      default: begin
        timer_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: all come from registers.
  always_comb begin
    o_char      = char_q;
    o_valid     = valid_q;
    o_frame_err = err_q;
    o_busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_char_r.sv
// tb_char_r: scoreboard bench for char_r. Four receivers run at 1, 4, 3 and
// 8 clocks per bit; stimulus pushes the expected pulse (kind, character and
// cycle) into a queue and a monitor pops and compares on every pulse.
module tb_char_r;

  localparam int NDUT = 4;
  localparam int CPB [NDUT] = '{1, 4, 3, 8};

  typedef struct packed {
    logic [1:0]  dut;
    logic        err;
    logic [7:0]  ch;
    logic [31:0] cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx   [NDUT];
  logic [7:0] chr  [NDUT];
  logic       vld  [NDUT];
  logic       ferr [NDUT];
  logic       busy [NDUT];

  int   n_cmp;
  int   n_bad;
  int   cyc;
  exp_t exp_q [$];
  exp_t mon_e;
  logic [7:0] exp_char [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    char_r #(
      .DATA_BITS   (8),
      .CLKS_PER_BIT(CPB[g])
    ) u_dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_rx       (rx[g]),
      .o_char     (chr[g]),
      .o_valid    (vld[g]),
      .o_frame_err(ferr[g]),
      .o_busy     (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard queue.
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < NDUT; d++) begin
        if (vld[d] || ferr[d]) begin
          chk("valid_err_exclusive", {31'b0, vld[d] & ferr[d]}, 32'd0);
          if (exp_q.size() == 0) begin
            chk("pulse_expected", 32'(exp_q.size()), 32'd1);
          end else begin
            mon_e = exp_q.pop_front();
            chk("pulse_dut", 32'(d), 32'(mon_e.dut));
            chk("pulse_kind", {31'b0, ferr[d]}, {31'b0, mon_e.err});
            chk("pulse_char", {24'b0, chr[d]}, {24'b0, mon_e.ch});
            chk("pulse_cycle", 32'(cyc), mon_e.cyc);
          end
        end
      end
    end
  end

  // Called at a falling edge; holds the bit for c clocks.
  task automatic drive_bit(input int d, input logic b, input int c);
    rx[d] = b;
    repeat (c) @(negedge clk);
  endtask

  // Sends one frame on receiver d and queues the expected pulse. The start
  // bit is seen at the next rising edge k; the stop sample lands at
  // k + 9*c + (c-1)/2.
  task automatic send(input int d, input logic [7:0] v, input logic sb);
    int   c;
    exp_t e;
    c     = CPB[d];
    e.dut = 2'(d);
    e.err = ~sb;
    e.ch  = sb ? v : exp_char[d];
    e.cyc = 32'(cyc + 1 + 9 * c + (c - 1) / 2);
    if (sb) exp_char[d] = v;
    exp_q.push_back(e);
    drive_bit(d, 1'b0, c);
    for (int i = 7; i >= 0; i--) drive_bit(d, v[i], c);
    drive_bit(d, sb, c);
  endtask

  initial begin
    int c;
    int w;
    logic [7:0] v;
    logic       sb;
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst   = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      rx[d]       = 1'b1;
      exp_char[d] = 8'h00;
    end
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("reset_char", {24'b0, chr[d]}, 32'd0);
      chk("reset_busy", {31'b0, busy[d]}, 32'd0);
      chk("reset_pulses", {30'b0, vld[d], ferr[d]}, 32'd0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single 0xA5 frame at one bit per clock.
    send(0, 8'hA5, 1'b1);
    repeat (3) @(negedge clk);

    // Bad stop bit, line held low: one error pulse, no new frame until high.
    send(0, 8'h3C, 1'b0);
    repeat (5) @(negedge clk);
    chk("wait_high_busy", {31'b0, busy[0]}, 32'd1);
    rx[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("wait_high_exit", {31'b0, busy[0]}, 32'd0);
    repeat (2) @(negedge clk);

    // Back-to-back frames, no idle gap.
    send(0, 8'h00, 1'b1);
    send(0, 8'hFF, 1'b1);
    repeat (3) @(negedge clk);

    // False start at four clocks per bit, then a real 0x81 frame.
    rx[1] = 1'b0;
    @(negedge clk);
    chk("false_start_busy", {31'b0, busy[1]}, 32'd1);
    rx[1] = 1'b1;
    @(negedge clk);
    chk("false_start_idle", {31'b0, busy[1]}, 32'd0);
    repeat (4) @(negedge clk);
    send(1, 8'h81, 1'b1);
    repeat (8) @(negedge clk);

    // Reset mid-DATA of a 0x5A frame.
    drive_bit(0, 1'b0, 1);
    drive_bit(0, 1'b0, 1);
    drive_bit(0, 1'b1, 1);
    drive_bit(0, 1'b0, 1);
    drive_bit(0, 1'b1, 1);
    chk("pre_reset_busy", {31'b0, busy[0]}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_char", {24'b0, chr[0]}, 32'd0);
    chk("async_reset_busy", {31'b0, busy[0]}, 32'd0);
    chk("async_reset_char1", {24'b0, chr[1]}, 32'd0);
    for (int d = 0; d < NDUT; d++) exp_char[d] = 8'h00;
    rx[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    send(0, 8'h5A, 1'b1);
    repeat (3) @(negedge clk);

    // Random frames at 1, 3 and 8 clocks per bit, some with bad stop bits.
    for (int k = 0; k < 3; k++) begin
      int d;
      d = (k == 0) ? 0 : k + 1;
      c = CPB[d];
      for (int f = 0; f < 6; f++) begin
        v  = 8'($urandom_range(0, 255));
        sb = ($urandom_range(0, 3) != 0);
        send(d, v, sb);
        if (!sb) begin
          w = $urandom_range(0, 4);
          repeat (w) @(negedge clk);
          rx[d] = 1'b1;
          repeat (c + 1) @(negedge clk);
        end
        w = $urandom_range(0, 2) * c;
        repeat (w) @(negedge clk);
      end
      repeat (2 * c) @(negedge clk);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
